// File: rtl/gshare_spec_predictor.sv
// gshare direction predictor with speculative global history and repair.
// Optional GSHARE_STATS_EN adds lookup and mispredict counters.
module gshare_spec_predictor #(
   parameter int IDX_WIDTH = 8,
   parameter int BHR_WIDTH = 8,
   parameter int PC_LSB    = 2,
   parameter int CTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pred_req,
   input  logic [31:0]          pred_pc,
   output logic                 pred_taken,
   output logic [BHR_WIDTH-1:0] pred_hist,
   input  logic                 upd_valid,
   input  logic [31:0]          upd_pc,
   input  logic [BHR_WIDTH-1:0] upd_hist,
   input  logic                 upd_taken,
   input  logic                 upd_mispredict
`ifdef GSHARE_STATS_EN
   ,
   output logic [31:0]          stat_lookups,
   output logic [31:0]          stat_mispred
`endif
);

   localparam int DEPTH = 2 ** IDX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT =
      CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

   if (BHR_WIDTH < 1 || BHR_WIDTH > IDX_WIDTH) begin : g_bad_bhr
      $error("BHR_WIDTH must be in 1..IDX_WIDTH");
   end

   logic [CTR_WIDTH-1:0] pht [DEPTH];
   logic [BHR_WIDTH-1:0] bhr;
   logic [BHR_WIDTH-1:0] bhr_next;
   logic [IDX_WIDTH-1:0] pred_idx;
   logic [IDX_WIDTH-1:0] upd_idx;
   logic [CTR_WIDTH-1:0] ctr_old;
   logic [CTR_WIDTH-1:0] ctr_next;
   logic                 repair;

   logic unused_pc_bits;
   assign unused_pc_bits = &{1'b0, pred_pc, upd_pc};

   function automatic logic [IDX_WIDTH-1:0] gidx(
      input logic [31:0]          pc,
      input logic [BHR_WIDTH-1:0] h
   );
      return pc[PC_LSB +: IDX_WIDTH] ^ IDX_WIDTH'(h);
   endfunction

   assign pred_idx   = gidx(pred_pc, bhr);
   assign upd_idx    = gidx(upd_pc, upd_hist);
   assign pred_taken = pht[pred_idx][CTR_WIDTH-1];
   assign pred_hist  = bhr;
   assign repair     = upd_valid & upd_mispredict;
   assign ctr_old    = pht[upd_idx];

   always_comb begin
      ctr_next = ctr_old;
      if (upd_taken) begin
         if (ctr_old != CTR_MAX) ctr_next = ctr_old + 1'b1;
      end else begin
         if (ctr_old != '0) ctr_next = ctr_old - 1'b1;
      end
   end

   // Repair beats the shift: that prediction came from a squashed path.
   always_comb begin
      bhr_next = bhr;
      if (repair) begin
         bhr_next = BHR_WIDTH'({upd_hist, upd_taken});
      end else if (pred_req) begin
         bhr_next = BHR_WIDTH'({bhr, pred_taken});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bhr <= '0;
      end else begin
         bhr <= bhr_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) pht[i] <= CTR_INIT;
      end else if (upd_valid) begin
         pht[upd_idx] <= ctr_next;
      end
   end

`ifdef GSHARE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_lookups <= '0;
         stat_mispred <= '0;
      end else begin
         if (pred_req) stat_lookups <= stat_lookups + 32'd1;
         if (repair)   stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed and random checks of gshare_spec_predictor at default parameters
// against a table-of-integers reference model.
module tb_gshare_spec_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        pred_req;
   logic [31:0] pred_pc;
   logic        pred_taken;
   logic [7:0]  pred_hist;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [7:0]  upd_hist;
   logic        upd_taken;
   logic        upd_mispredict;
`ifdef GSHARE_STATS_EN
   logic [31:0] stat_lookups;
   logic [31:0] stat_mispred;
`endif

   always #5 clk = ~clk;

   gshare_spec_predictor dut (
      .clk(clk),
      .rst(rst),
      .pred_req(pred_req),
      .pred_pc(pred_pc),
      .pred_taken(pred_taken),
      .pred_hist(pred_hist),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_hist(upd_hist),
      .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict)
`ifdef GSHARE_STATS_EN
      ,
      .stat_lookups(stat_lookups),
      .stat_mispred(stat_mispred)
`endif
   );

   int m_pht [256];
   int m_bhr;
   int m_look;
   int m_mis;
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input logic [31:0] pc, input int h);
      return (int'(pc >> 2) & 255) ^ h;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_bhr  = 0;
      m_look = 0;
      m_mis  = 0;
   endtask

   task automatic drive(input logic req, input logic [31:0] pc,
                        input logic uv, input logic [31:0] upc,
                        input logic [7:0] uh, input logic ut,
                        input logic um);
      pred_req       = req;
      pred_pc        = pc;
      upd_valid      = uv;
      upd_pc         = upc;
      upd_hist       = uh;
      upd_taken      = ut;
      upd_mispredict = um;
   endtask

   // Check this cycle's prediction, then advance model across one edge.
   task automatic step(input string tag);
      int pt;
      int nb;
      int ui;
      #2;
      pt = (m_pht[idx(pred_pc, m_bhr)] >= 2) ? 1 : 0;
      chk({tag, ".taken"}, 32'(pred_taken), 32'(pt));
      chk({tag, ".hist"}, 32'(pred_hist), 32'(m_bhr));
      nb = m_bhr;
      if (pred_req) begin
         nb = ((m_bhr << 1) | pt) & 255;
         m_look++;
      end
      if (upd_valid) begin
         ui = idx(upd_pc, int'(upd_hist));
         if (upd_taken) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
         else           m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
         if (upd_mispredict) begin
            nb = ((int'(upd_hist) << 1) | int'(upd_taken)) & 255;
            m_mis++;
         end
      end
      @(posedge clk);
      #1;
      m_bhr = nb;
   endtask

   task automatic async_reset();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst.hist", 32'(pred_hist), 32'h0);
      chk("rst.taken", 32'(pred_taken), 32'h0);
`ifdef GSHARE_STATS_EN
      chk("rst.lookups", stat_lookups, 32'h0);
      chk("rst.mispred", stat_mispred, 32'h0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b1, 32'h100, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      model_reset();
      #1;
      chk("t1.held_taken", 32'(pred_taken), 32'h0);
      chk("t1.held_hist", 32'(pred_hist), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;

      step("t1.pred");
      drive(1'b0, 32'h100, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("t1.next_hist", 32'(pred_hist), 32'h0);

      // Saturation: three ups from 01 must stay taken, not wrap.
      drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
      repeat (3) step("t2.up");
      drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("t2.sat_taken", 32'(pred_taken), 32'h1);
      step("t2.pred");
      drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
      step("t2.down1");
      drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("t2.after_down", 32'(pred_taken), 32'h1);
      drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
      step("t2.down2");

      drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
      repeat (2) step("t3.train0");
      drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h01, 1'b1, 1'b0);
      repeat (2) step("t3.train1");
      drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      step("t3.shift1");
      chk("t3.bhr01", 32'(pred_hist), 32'h01);
      step("t3.shift2");
      chk("t3.bhr03", 32'(pred_hist), 32'h03);
      drive(1'b1, 32'h40, 1'b1, 32'h80, 8'h00, 1'b0, 1'b1);
      step("t3.repair");
      chk("t3.repaired", 32'(pred_hist), 32'h00);

      drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
      repeat (2) step("t4.untrain10");
      drive(1'b0, 32'h0, 1'b1, 32'h0, 8'h00, 1'b1, 1'b0);
      repeat (2) step("t4.train00");
      drive(1'b0, 32'h40, 1'b1, 32'h400, 8'h08, 1'b0, 1'b1);
      step("t4.set_bhr");
      drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("t4.bhr10", 32'(pred_hist), 32'h10);
      chk("t4.xor_taken", 32'(pred_taken), 32'h1);
      step("t4.pred");

      drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      async_reset();
      drive(1'b1, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
      step("t5.same");
      drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
      chk("t5.next_taken", 32'(pred_taken), 32'h1);
      step("t5.next");

`ifdef GSHARE_STATS_EN
      async_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(i * 4), (i == 1 || i == 3), 32'h40, 8'h0,
               1'b1, 1'b1);
         step("t6.stats");
      end
      chk("t6.lookups", stat_lookups, 32'd5);
      chk("t6.mispred", stat_mispred, 32'd2);
`endif

      // Small PC range and reused histories force aliasing and repairs.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)),
               32'($urandom_range(0, 31) << 2),
               1'($urandom_range(0, 1)),
               32'($urandom_range(0, 31) << 2),
               8'($urandom_range(0, 3) == 0 ? $urandom : m_bhr),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0));
         step("rnd");
      end
`ifdef GSHARE_STATS_EN
      chk("rnd.lookups", stat_lookups, 32'(m_look));
      chk("rnd.mispred", stat_mispred, 32'(m_mis));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
